cmp_sort_ctrl: RTL and testbench

//   Sequencer that sorts a block of DEPTH 8-bit samples using one shared 8-bit magnitude

---
 rtl/cmp_sort_pkg.sv | 27 ++
 rtl/data_cmp8.sv | 26 ++
 rtl/cmp_sort_ctrl.sv | 170 +++++++++++++++++
 tb/tb_cmp_sort_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_sort_pkg.sv
// -----------------------------------------------------------------------------
// cmp_sort_pkg
//   Definitions shared by the block sorter and its comparator:
//     state_t     - sequencer states (LOAD, SORT, OUT)
//     CMP_*       - bit positions inside the 3-bit comparator result {gt,eq,lt}
//     sortCycles  - number of SORT cycles needed for a block of 'depth' samples
// -----------------------------------------------------------------------------
package cmp_sort_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SORT = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Comparator result bit positions; exactly one of these is set.
  localparam int CMP_GT = 2;
  localparam int CMP_EQ = 1;
  localparam int CMP_LT = 0;

  // A full bubble sort with no early exit performs this many compares,
  // one per clock.
  function automatic int sortCycles(input int depth);
    return depth * (depth - 1) / 2;
  endfunction

endpackage

// File: rtl/data_cmp8.sv
// -----------------------------------------------------------------------------
// data_cmp8
//   Single combinational 8-bit unsigned magnitude comparator.
//   Ports:
//     iData_a  in  [7:0]  operand A
//     iData_b  in  [7:0]  operand B
//     oData    out [2:0]  {A>B, A==B, A<B}, one-hot
// -----------------------------------------------------------------------------
module data_cmp8
  import cmp_sort_pkg::*;
(
  input  logic [7:0] iData_a,
  input  logic [7:0] iData_b,
  output logic [2:0] oData
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    oData         = '0;
    oData[CMP_GT] = (iData_a >  iData_b);
    oData[CMP_EQ] = (iData_a == iData_b);
    oData[CMP_LT] = (iData_a <  iData_b);
  end

endmodule

// File: rtl/cmp_sort_ctrl.sv
// -----------------------------------------------------------------------------
// cmp_sort_ctrl
//   Block sorter: accepts DEPTH samples over a valid/ready stream, bubble-sorts
//   them in place using one shared 8-bit comparator (one compare per clock),
//   then streams them out ascending (iDesc=0) or descending (iDesc=1).
//
//   Parameters:
//     WIDTH  sample width; the comparator is 8 bits wide, so only 8 is legal
//     DEPTH  samples per block, 2..16
//
//   Ports:
//     iClk    in   clock, rising edge
//     iRst    in   synchronous reset, active-high; aborts any block in flight
//     iData   in   input sample
//     iValid  in   iData valid
//     oReady  out  sample accepted when high (LOAD only)
//     iDesc   in   order select, sampled with the first sample of a block
//     oData   out  output sample, mem[rdIdx]
//     oValid  out  oData valid (OUT only)
//     iReady  in   consumer accepts oData
//     oLast   out  final sample of the block is on oData
//     oBusy   out  sorting in progress
// -----------------------------------------------------------------------------
module cmp_sort_ctrl
  import cmp_sort_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [WIDTH-1:0] iData,
  input  logic             iValid,
  output logic             oReady,
  input  logic             iDesc,
  output logic [WIDTH-1:0] oData,
  output logic             oValid,
  input  logic             iReady,
  output logic             oLast,
  output logic             oBusy
);

  localparam int IDX_W = $clog2(DEPTH);
  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t LAST_IDX  = idx_t'(DEPTH - 1);
  localparam idx_t LAST_PASS = idx_t'(DEPTH - 2);

  state_t     state;
  // Register array rather than RAM: a swap writes two entries in one cycle.
  logic [WIDTH-1:0] mem [DEPTH];
  idx_t       wrIdx;
  idx_t       rdIdx;
  idx_t       pass;
  idx_t       j;
  logic       desc;

  // ---------------------------------------------------------------------------
  // Shared comparator, always looking at the adjacent pair (mem[j], mem[j+1]).
  // j never exceeds DEPTH-2, so j+1 stays inside the array.
  // ---------------------------------------------------------------------------
  idx_t       jNext;
  logic [2:0] cmp;
  logic       swap;
  logic       passEnd;
  logic       lastCompare;

  assign jNext = j + idx_t'(1);

  data_cmp8 uCmp (
    .iData_a (mem[j]),
    .iData_b (mem[jNext]),
    .oData   (cmp)
  );

  // Equal values never swap, which keeps the sort stable.
  assign swap        = (!desc && cmp[CMP_GT]) || (desc && cmp[CMP_LT]);
  // Each pass bubbles one more element into its final slot, so the pass
  // shrinks by one compare each time.
  assign passEnd     = (j == (LAST_PASS - pass));
  assign lastCompare = (pass == LAST_PASS) && (j == '0);

  // ---------------------------------------------------------------------------
  // Sequencer and datapath state
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk) begin
    if (iRst) begin
      // NOTE: state is written with non-blocking assignments so every
      // register samples the pre-edge values of the others.
      state <= LOAD;
      wrIdx <= '0;
      rdIdx <= '0;
      pass  <= '0;
      j     <= '0;
      desc  <= 1'b0;
      // NOTE: the sample array is cleared on reset so an aborted block can
      // never leak onto oData; a register array (not RAM) makes this legal.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (state)
        LOAD: begin
          if (iValid) begin
            mem[wrIdx] <= iData;
            // The sort order belongs to the block and is fixed by its first
            // sample; later iDesc values are ignored.
            if (wrIdx == '0) begin
              desc <= iDesc;
            end
            if (wrIdx == LAST_IDX) begin
              wrIdx <= '0;
              pass  <= '0;
              j     <= '0;
              state <= SORT;
            end else begin
              wrIdx <= wrIdx + idx_t'(1);
            end
          end
        end

        SORT: begin
          if (swap) begin
            mem[j]     <= mem[jNext];
            mem[jNext] <= mem[j];
          end
          if (passEnd) begin
            j    <= '0;
            pass <= pass + idx_t'(1);
          end else begin
            j <= jNext;
          end
          // Fixed-length sort: no early exit even if the data is already
          // in order, so the latency is constant.
          if (lastCompare) begin
            pass  <= '0;
            state <= OUT;
          end
        end

        OUT: begin
          if (iReady) begin
            if (rdIdx == LAST_IDX) begin
              rdIdx <= '0;
              state <= LOAD;
            end else begin
              rdIdx <= rdIdx + idx_t'(1);
            end
          end
        end

        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: pure decodes of registered state, so they are glitch-free and
  // change only on the clock edge. An illegal state encoding drives all
  // handshakes low for one cycle before recovering to LOAD.
  // ---------------------------------------------------------------------------
  assign oReady = (state == LOAD);
  assign oBusy  = (state == SORT);
  assign oValid = (state == OUT);
  assign oLast  = oValid && (rdIdx == LAST_IDX);
  assign oData  = mem[rdIdx];

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cmp_sort_ctrl
//   Self-checking bench for cmp_sort_ctrl (WIDTH=8, DEPTH=4). Expected output
//   order comes from a queue model: the loaded block, sorted, then reversed
//   for descending blocks.
// -----------------------------------------------------------------------------
module tb_cmp_sort_ctrl;

  localparam int WIDTH      = 8;
  localparam int DEPTH      = 4;
  localparam int SORT_CYC   = DEPTH * (DEPTH - 1) / 2;
  localparam int LOOP_LIMIT = 200;

  logic             clk;
  logic             iRst;
  logic [WIDTH-1:0] iData;
  logic             iValid;
  logic             oReady;
  logic             iDesc;
  logic [WIDTH-1:0] oData;
  logic             oValid;
  logic             iReady;
  logic             oLast;
  logic             oBusy;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [WIDTH-1:0] blk [DEPTH];
  logic             blkDesc;
  logic [WIDTH-1:0] expQ [$];

  cmp_sort_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .iClk   (clk),
    .iRst   (iRst),
    .iData  (iData),
    .iValid (iValid),
    .oReady (oReady),
    .iDesc  (iDesc),
    .oData  (oData),
    .oValid (oValid),
    .iReady (iReady),
    .oLast  (oLast),
    .oBusy  (oBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end of test, required end within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the block in sorted order, reversed when descending.
  function automatic void buildExpected();
    expQ.delete();
    foreach (blk[i]) expQ.push_back(blk[i]);
    expQ.sort();
    if (blkDesc) expQ.reverse();
  endfunction

  task automatic setBlock(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d, input logic desc);
    blk[0] = a; blk[1] = b; blk[2] = c; blk[3] = d;
    blkDesc = desc;
  endtask

  // Feed blk[] into the DUT. With randValid, iValid toggles randomly and junk
  // data/order bits are driven on idle cycles; iReady is noise in LOAD.
  task automatic loadBlock(input bit randValid);
    int i = 0;
    int guard = 0;
    while (i < DEPTH && guard < LOOP_LIMIT) begin
      guard++;
      iReady = 1'($urandom);
      iValid = randValid ? 1'($urandom) : 1'b1;
      iData  = iValid ? blk[i] : 8'($urandom);
      iDesc  = (iValid && i == 0) ? blkDesc : 1'($urandom);
      check("load_ready", 32'(oReady), 32'd1);
      step();
      if (iValid) i++;
    end
    check("load_count", 32'(i), 32'(DEPTH));
    iValid = 1'b0;
    iReady = 1'b0;
    iDesc  = 1'b0;
  endtask

  // Count SORT cycles; with noisy, drive iValid/iData/iReady during the sort.
  task automatic sortPhase(input bit noisy);
    int cnt = 0;
    while (oBusy && cnt < LOOP_LIMIT) begin
      check("sort_ready_low", 32'(oReady), 32'd0);
      check("sort_valid_low", 32'(oValid), 32'd0);
      if (noisy) begin
        iValid = 1'($urandom);
        iData  = 8'($urandom);
        iReady = 1'($urandom);
      end
      cnt++;
      step();
    end
    iValid = 1'b0;
    iReady = 1'b0;
    check("sort_cycles", 32'(cnt), 32'(SORT_CYC));
    check("out_valid", 32'(oValid), 32'd1);
  endtask

  // Drain the block, comparing against the model. stallAt/stallLen force a
  // fixed stall before one sample; noisy adds random stalls and iValid noise.
  task automatic unloadBlock(input bit noisy, input int stallAt, input int stallLen);
    int nStall;
    buildExpected();
    for (int k = 0; k < DEPTH; k++) begin
      nStall = (k == stallAt) ? stallLen : (noisy ? int'($urandom_range(0, 2)) : 0);
      for (int s = 0; s < nStall; s++) begin
        iReady = 1'b0;
        iValid = noisy ? 1'($urandom) : 1'b0;
        iData  = 8'($urandom);
        check("stall_valid", 32'(oValid), 32'd1);
        check("stall_data", 32'(oData), 32'(expQ[k]));
        step();
      end
      iReady = 1'b1;
      iValid = noisy ? 1'($urandom) : 1'b0;
      check("out_valid", 32'(oValid), 32'd1);
      check("out_data", 32'(oData), 32'(expQ[k]));
      check("out_last", 32'(oLast), (k == DEPTH - 1) ? 32'd1 : 32'd0);
      check("out_busy", 32'(oBusy), 32'd0);
      step();
    end
    iReady = 1'b0;
    iValid = 1'b0;
    check("back_ready", 32'(oReady), 32'd1);
    check("back_valid", 32'(oValid), 32'd0);
    check("back_last", 32'(oLast), 32'd0);
  endtask

  task automatic runBlock(input bit noisy, input int stallAt, input int stallLen);
    loadBlock(noisy);
    sortPhase(noisy);
    unloadBlock(noisy, stallAt, stallLen);
  endtask

  initial begin
    iRst   = 1'b1;
    iData  = '0;
    iValid = 1'b0;
    iDesc  = 1'b0;
    iReady = 1'b0;
    step();
    step();
    check("rst_ready", 32'(oReady), 32'd1);
    check("rst_valid", 32'(oValid), 32'd0);
    check("rst_last", 32'(oLast), 32'd0);
    check("rst_busy", 32'(oBusy), 32'd0);
    check("rst_data", 32'(oData), 32'd0);
    iRst = 1'b0;

    // Basic ascending block.
    setBlock(8'h30, 8'h10, 8'h40, 8'h20, 1'b0);
    runBlock(1'b0, -1, 0);

    // Same data descending, then the next block must revert to ascending.
    setBlock(8'h30, 8'h10, 8'h40, 8'h20, 1'b1);
    runBlock(1'b0, -1, 0);
    setBlock(8'h22, 8'h88, 8'h11, 8'h44, 1'b0);
    runBlock(1'b0, -1, 0);

    // Duplicates and extremes; already-sorted input still takes full time.
    setBlock(8'hFF, 8'h00, 8'hFF, 8'h00, 1'b0);
    runBlock(1'b0, -1, 0);
    setBlock(8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
    runBlock(1'b0, -1, 0);

    // Three-cycle consumer stall, random iValid in LOAD.
    setBlock(8'h7A, 8'h03, 8'hC5, 8'h3C, 1'b1);
    runBlock(1'b1, 1, 3);

    // Reset during the third SORT cycle aborts the block.
    setBlock(8'hAA, 8'h55, 8'hCC, 8'h33, 1'b1);
    loadBlock(1'b0);
    check("abort_busy1", 32'(oBusy), 32'd1);
    step();
    step();
    check("abort_busy3", 32'(oBusy), 32'd1);
    iRst = 1'b1;
    step();
    iRst = 1'b0;
    check("abort_ready", 32'(oReady), 32'd1);
    check("abort_valid", 32'(oValid), 32'd0);
    check("abort_busy", 32'(oBusy), 32'd0);
    check("abort_data", 32'(oData), 32'd0);
    setBlock(8'h05, 8'h03, 8'h09, 8'h01, 1'b0);
    runBlock(1'b0, -1, 0);

    // Noise on the inactive handshakes in SORT and OUT.
    setBlock(8'h90, 8'h90, 8'h10, 8'h50, 1'b1);
    runBlock(1'b1, 0, 2);

    // Randomized blocks.
    for (int b = 0; b < 30; b++) begin
      for (int i = 0; i < DEPTH; i++) begin
        blk[i] = 8'($urandom);
      end
      if ($urandom_range(0, 3) == 0) blk[1] = blk[3];
      blkDesc = 1'($urandom);
      runBlock(1'b1, -1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
